// File: rtl/loader_pkg.sv
// Shared types and derivation helpers for the UART program loader.
`timescale 1ns/1ps
package loader_pkg;

   typedef enum logic [2:0] {IDLE, CNT, DATA, CHK, DONE, ERR} state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

   localparam int unsigned COUNT_BYTES = 2;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, framing check on the stop bit.
`timescale 1ns/1ps
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic      rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // A true high-to-low edge is required, so a held-low line after a framing error is not a start bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync_q ? RX_IDLE : RX_BITS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_BITS: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = rx_sync_q;
               ferr_d  = !rx_sync_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rx_data      = shift_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART boot loader: 16-bit LE word count, then DATA_W-bit LE words written to instruction RAM.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit modular-sum byte after the last word.
`timescale 1ns/1ps
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUD         = 9600,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned MAX_WORDS    = 256,
   parameter int unsigned TIMEOUT_BITS = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              load_req,
   input  logic              uart_rx_pin,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned BPW      = bytes_per_word(DATA_W);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CPB;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
   localparam int unsigned BC_W     = $clog2(BPW + COUNT_BYTES);

   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .rx_i         (uart_rx_pin),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err)
   );

   state_e            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              started_q, started_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic              active;
   logic [15:0]       count_next;
   logic [DATA_W-1:0] word_next;
   logic              last_word;

   assign active     = (state_q == CNT) || (state_q == DATA) || (state_q == CHK);
   assign count_next = {rx_data, count_q[15:8]};
   assign word_next  = (word_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
   assign last_word  = (32'(index_q) + 32'd1) == 32'(count_q);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         count_q    <= '0;
         index_q    <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         started_q  <= 1'b0;
         to_cnt_q   <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         index_q    <= index_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         started_q  <= started_d;
         to_cnt_q   <= to_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      index_d    = index_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      started_d  = started_q;
      to_cnt_d   = to_cnt_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif

      if (active && started_q) to_cnt_d = to_cnt_q + 1'b1;
      if (active && rx_valid) begin
         started_d = 1'b1;
         to_cnt_d  = '0;
      end

      unique case (state_q)
         CNT: begin
            if (rx_frame_err) begin
               state_d = ERR;
            end else if (rx_valid) begin
               count_d = count_next;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = sum_q + rx_data;
`endif
               if (byte_cnt_q == BC_W'(COUNT_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  if (count_next == 16'd0)                 state_d = DONE;
                  else if (32'(count_next) > MAX_WORDS)    state_d = ERR;
                  else                                     state_d = DATA;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (rx_frame_err) begin
               state_d = ERR;
            end else if (rx_valid) begin
               word_d = word_next;
`ifdef LOADER_CHECKSUM_EN
               sum_d  = sum_q + rx_data;
`endif
               if (byte_cnt_q == BC_W'(BPW - 1)) begin
                  byte_cnt_d = '0;
                  we_d       = 1'b1;
                  addr_d     = index_q;
                  wdata_d    = word_next;
                  index_d    = index_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  if (last_word) state_d = CHK;
`else
                  if (last_word) state_d = DONE;
`endif
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (rx_frame_err)  state_d = ERR;
            else if (rx_valid) state_d = (rx_data == sum_q) ? DONE : ERR;
         end
`endif
         default: ;
      endcase

      if (active && started_q && !rx_valid && (to_cnt_q == TO_W'(TO_LIMIT - 1)))
         state_d = ERR;

      // Restart overrides state but leaves we_d alone, so a final write decided this cycle still lands.
      if (load_req) begin
         state_d    = CNT;
         count_d    = '0;
         index_d    = '0;
         byte_cnt_d = '0;
         word_d     = '0;
         started_d  = 1'b0;
         to_cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
         sum_d      = '0;
`endif
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_hold  = active;
   assign load_done = (state_q == DONE);
   assign load_err  = (state_q == ERR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a 16-bit instance and a 32-bit instance at short bit times.
`timescale 1ns/1ps
module tb_uart_program_loader;

   localparam int unsigned CPB_A = 16;
   localparam int unsigned CPB_B = 8;

   logic clk = 1'b0;
   logic rst;
   logic req_a, rx_a, we_a, hold_a, done_a, err_a;
   logic [7:0]  addr_a;
   logic [15:0] wdata_a;
   logic req_b, rx_b, we_b, hold_b, done_b, err_b;
   logic [7:0]  addr_b;
   logic [31:0] wdata_b;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sum_m;

   logic [7:0]  wa_addr[$];
   logic [15:0] wa_data[$];
   logic [7:0]  wb_addr[$];
   logic [31:0] wb_data[$];

   always #5 clk = ~clk;

   uart_program_loader #(
      .CLK_FREQ(1_000_000), .BAUD(62_500), .DATA_W(16), .ADDR_W(8),
      .MAX_WORDS(256), .TIMEOUT_BITS(64)
   ) dut_a (
      .CLK(clk), .RESET(rst), .load_req(req_a), .uart_rx_pin(rx_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a)
   );

   uart_program_loader #(
      .CLK_FREQ(1_000_000), .BAUD(125_000), .DATA_W(32), .ADDR_W(8),
      .MAX_WORDS(256), .TIMEOUT_BITS(64)
   ) dut_b (
      .CLK(clk), .RESET(rst), .load_req(req_b), .uart_rx_pin(rx_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b)
   );

   always @(negedge clk) begin
      if (we_a === 1'b1) begin
         wa_addr.push_back(addr_a);
         wa_data.push_back(wdata_a);
      end
      if (we_b === 1'b1) begin
         wb_addr.push_back(addr_b);
         wb_data.push_back(wdata_b);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input bit inst, input logic v);
      if (inst) rx_b = v;
      else      rx_a = v;
   endtask

   task automatic send_byte(input bit inst, input logic [7:0] b, input logic stop_bit);
      int unsigned cpb;
      cpb = inst ? CPB_B : CPB_A;
      sum_m = sum_m + b;
      set_rx(inst, 1'b0);
      wait_cycles(cpb);
      for (int i = 0; i < 8; i++) begin
         set_rx(inst, b[i]);
         wait_cycles(cpb);
      end
      set_rx(inst, stop_bit);
      wait_cycles(cpb);
      set_rx(inst, 1'b1);
      wait_cycles(cpb);
   endtask

   task automatic pulse_req(input bit inst);
      sum_m = 8'h00;
      if (inst) req_b = 1'b1;
      else      req_a = 1'b1;
      wait_cycles(1);
      req_a = 1'b0;
      req_b = 1'b0;
      wait_cycles(1);
   endtask

   task automatic send_chk(input bit inst);
      logic [7:0] s;
      s = sum_m;
      send_byte(inst, s, 1'b1);
   endtask

   task automatic clear_logs();
      wa_addr.delete();
      wa_data.delete();
      wb_addr.delete();
      wb_data.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      sum_m = 8'h00;
      wait_cycles(5);
      check("rst_outs_a", {we_a, hold_a, done_a, err_a, addr_a, wdata_a}, '0);
      check("rst_outs_b", {we_b, hold_b, done_b, err_b, addr_b, wdata_b}, '0);
      rst = 1'b0;
      wait_cycles(2);

      // Test 1: three 16-bit words
      clear_logs();
      pulse_req(0);
      check("t1_hold_during", hold_a, 1);
      send_byte(0, 8'h03, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h34, 1); send_byte(0, 8'h12, 1);
      send_byte(0, 8'hCD, 1); send_byte(0, 8'hAB, 1);
      send_byte(0, 8'h0F, 1); send_byte(0, 8'h0F, 1);
`ifdef LOADER_CHECKSUM_EN
      send_chk(0);
`endif
      wait_cycles(2);
      check("t1_nwr", 64'(wa_addr.size()), 3);
      check("t1_a0", {wa_addr[0], wa_data[0]}, {8'd0, 16'h1234});
      check("t1_a1", {wa_addr[1], wa_data[1]}, {8'd1, 16'hABCD});
      check("t1_a2", {wa_addr[2], wa_data[2]}, {8'd2, 16'h0F0F});
      check("t1_status", {hold_a, done_a, err_a}, 3'b010);

      // Test 2: zero count, load_req clears done
      clear_logs();
      pulse_req(0);
      check("t2_cleared", {hold_a, done_a, err_a}, 3'b100);
      send_byte(0, 8'h00, 1); send_byte(0, 8'h00, 1);
      check("t2_status", {hold_a, done_a, err_a}, 3'b010);
      check("t2_nwr", 64'(wa_addr.size()), 0);

      // Test 3: count 257 exceeds MAX_WORDS
      pulse_req(0);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h01, 1);
      check("t3_status", {hold_a, done_a, err_a}, 3'b001);
      check("t3_nwr", 64'(wa_addr.size()), 0);

      // Test 4: framing error mid-load, then recovery
      pulse_req(0);
      check("t4_err_cleared", err_a, 0);
      send_byte(0, 8'h02, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h55, 1); send_byte(0, 8'h55, 1);
      send_byte(0, 8'h11, 0);
      wait_cycles(2 * CPB_A);
      check("t4_nwr", 64'(wa_addr.size()), 1);
      check("t4_w0", {wa_addr[0], wa_data[0]}, {8'd0, 16'h5555});
      check("t4_status", {hold_a, done_a, err_a}, 3'b001);
      clear_logs();
      pulse_req(0);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h88, 1); send_byte(0, 8'h77, 1);
`ifdef LOADER_CHECKSUM_EN
      send_chk(0);
`endif
      wait_cycles(2);
      check("t4_recover_status", {hold_a, done_a, err_a}, 3'b010);
      check("t4_recover_w0", {64'(wa_addr.size()), wa_addr[0], wa_data[0]}, {64'd1, 8'd0, 16'h7788});

      // Reset mid-load aborts; later bytes are ignored
      clear_logs();
      pulse_req(0);
      send_byte(0, 8'h02, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h34, 1);
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      check("rst_mid_outs", {we_a, hold_a, done_a, err_a}, 4'b0000);
      send_byte(0, 8'h12, 1); send_byte(0, 8'h56, 1); send_byte(0, 8'h78, 1);
      wait_cycles(2);
      check("rst_mid_nwr", 64'(wa_addr.size()), 0);
      check("rst_mid_idle", {hold_a, done_a, err_a}, 3'b000);

      // Test 5: 32-bit instance, one word then a timeout
      pulse_req(1);
      send_byte(1, 8'h01, 1); send_byte(1, 8'h00, 1);
      send_byte(1, 8'hEF, 1); send_byte(1, 8'hBE, 1);
      send_byte(1, 8'hAD, 1); send_byte(1, 8'hDE, 1);
`ifdef LOADER_CHECKSUM_EN
      send_chk(1);
`endif
      wait_cycles(2);
      check("t5_nwr", 64'(wb_addr.size()), 1);
      check("t5_w0", {wb_addr[0], wb_data[0]}, {8'd0, 32'hDEADBEEF});
      check("t5_status", {hold_b, done_b, err_b}, 3'b010);
      clear_logs();
      pulse_req(1);
      send_byte(1, 8'h01, 1); send_byte(1, 8'h00, 1);
      send_byte(1, 8'h11, 1); send_byte(1, 8'h22, 1);
      wait_cycles(61 * CPB_B);
      check("t5_before_timeout", {hold_b, err_b}, 2'b10);
      wait_cycles(3 * CPB_B);
      check("t5_after_timeout", {hold_b, done_b, err_b}, 3'b001);
      check("t5_timeout_nwr", 64'(wb_addr.size()), 0);

`ifdef LOADER_CHECKSUM_EN
      // Test 6: checksum match and mismatch
      clear_logs();
      pulse_req(0);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h02, 1);
      check("t6_hold_in_chk", hold_a, 1);
      send_byte(0, 8'h04, 1);
      check("t6_good_status", {hold_a, done_a, err_a}, 3'b010);
      check("t6_good_w0", {64'(wa_addr.size()), wa_addr[0], wa_data[0]}, {64'd1, 8'd0, 16'h0201});
      clear_logs();
      pulse_req(0);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h00, 1);
      send_byte(0, 8'h01, 1); send_byte(0, 8'h02, 1);
      send_byte(0, 8'h05, 1);
      check("t6_bad_status", {hold_a, done_a, err_a}, 3'b001);
      check("t6_bad_w0", {64'(wa_addr.size()), wa_addr[0], wa_data[0]}, {64'd1, 8'd0, 16'h0201});
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
